// File: rtl/sifh_hist_rmw_ctrl.sv
// SiFH histogram SRAM sequencer: clear, read-modify-write accumulate, drain,
// then clear-on-read readout over a dual-port (1R/1W) SRAM.
module sifh_hist_rmw_ctrl #(
  parameter int DATA_W = 10,
  parameter int BIN_W  = 4,
  parameter int PIX_W  = 2,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = PIX_W + BIN_W
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              frame_done,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] din_data,
  input  logic [PIX_W-1:0]  din_pix,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_ren,
  input  logic [CNT_W-1:0]  ram_rdata,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_wen,
  output logic [CNT_W-1:0]  ram_wdata,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_count,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ACCUM   = 3'd2,
    DRAIN   = 3'd3,
    READOUT = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) satInc = CNT_MAX;
    else              satInc = v + CNT_W'(1);
  endfunction

  state_t              state_r;
  logic [ADDR_W-1:0]   sweep_r;
  logic                drainCnt_r;
  logic                s1Valid_r;
  logic [ADDR_W-1:0]   s1Addr_r;
  logic                fwdValid_r;
  logic [ADDR_W-1:0]   fwdAddr_r;
  logic [CNT_W-1:0]    fwdData_r;
  logic                rdIssue_r;
  logic                rdPend_r;
  logic [ADDR_W-1:0]   rdAddr_r;
  logic                done_r;

  logic [ADDR_W-1:0]   sampleAddr_s;
  logic [CNT_W-1:0]    baseCnt_s;
  logic [CNT_W-1:0]    incCnt_s;
  logic                unusedBits_s;

  assign sampleAddr_s = {din_pix, din_data[DATA_W-1 -: BIN_W]};
  assign unusedBits_s = ^din_data[DATA_W-BIN_W-1:0];
  // The SRAM returns stale data when read and written in the same cycle; the forward register covers it.
  assign baseCnt_s = (fwdValid_r && (fwdAddr_r == s1Addr_r)) ? fwdData_r : ram_rdata;
  assign incCnt_s  = satInc(baseCnt_s);

  assign din_ready = (state_r == ACCUM);
  assign busy      = (state_r != IDLE);
  assign rd_valid  = rdPend_r;
  assign rd_addr   = rdAddr_r;
  assign rd_count  = rdPend_r ? ram_rdata : {CNT_W{1'b0}};
  assign done      = done_r;

  // SRAM port steering per state
  always_comb begin
    ram_ren   = 1'b0;
    ram_raddr = {ADDR_W{1'b0}};
    ram_wen   = 1'b0;
    ram_waddr = {ADDR_W{1'b0}};
    ram_wdata = {CNT_W{1'b0}};
    case (state_r)
      CLEAR: begin
        ram_wen   = 1'b1;
        ram_waddr = sweep_r;
      end
      ACCUM: begin
        if (din_valid) begin
          ram_ren   = 1'b1;
          ram_raddr = sampleAddr_s;
        end else begin
          ram_ren   = 1'b0;
        end
        if (s1Valid_r) begin
          ram_wen   = 1'b1;
          ram_waddr = s1Addr_r;
          ram_wdata = incCnt_s;
        end else begin
          ram_wen   = 1'b0;
        end
      end
      DRAIN: begin
        if (s1Valid_r) begin
          ram_wen   = 1'b1;
          ram_waddr = s1Addr_r;
          ram_wdata = incCnt_s;
        end else begin
          ram_wen   = 1'b0;
        end
      end
      READOUT: begin
        if (rdIssue_r) begin
          ram_ren   = 1'b1;
          ram_raddr = sweep_r;
        end else begin
          ram_ren   = 1'b0;
        end
        if (rdPend_r) begin
          ram_wen   = 1'b1;
          ram_waddr = rdAddr_r;
        end else begin
          ram_wen   = 1'b0;
        end
      end
      default: begin
        ram_ren = 1'b0;
      end
    endcase
  end

  // Phase sequencer, RMW pipeline and readout pipeline
  always_ff @(posedge clk) begin
    if (!res) begin
      state_r    <= IDLE;
      sweep_r    <= {ADDR_W{1'b0}};
      drainCnt_r <= 1'b0;
      s1Valid_r  <= 1'b0;
      s1Addr_r   <= {ADDR_W{1'b0}};
      fwdValid_r <= 1'b0;
      fwdAddr_r  <= {ADDR_W{1'b0}};
      fwdData_r  <= {CNT_W{1'b0}};
      rdIssue_r  <= 1'b0;
      rdPend_r   <= 1'b0;
      rdAddr_r   <= {ADDR_W{1'b0}};
      done_r     <= 1'b0;
    end else begin
      s1Valid_r  <= (state_r == ACCUM) && din_valid;
      s1Addr_r   <= sampleAddr_s;
      fwdValid_r <= s1Valid_r;
      fwdAddr_r  <= s1Addr_r;
      fwdData_r  <= incCnt_s;
      rdPend_r   <= rdIssue_r;
      rdAddr_r   <= sweep_r;
      done_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= CLEAR;
            sweep_r <= {ADDR_W{1'b0}};
          end
        end
        CLEAR: begin
          sweep_r <= sweep_r + ADDR_W'(1);
          if (sweep_r == LAST_ADDR) state_r <= ACCUM;
        end
        ACCUM: begin
          if (frame_done) begin
            state_r    <= DRAIN;
            drainCnt_r <= 1'b0;
          end
        end
        DRAIN: begin
          drainCnt_r <= 1'b1;
          if (drainCnt_r) begin
            state_r   <= READOUT;
            sweep_r   <= {ADDR_W{1'b0}};
            rdIssue_r <= 1'b1;
          end
        end
        READOUT: begin
          if (rdIssue_r) begin
            sweep_r <= sweep_r + ADDR_W'(1);
            if (sweep_r == LAST_ADDR) rdIssue_r <= 1'b0;
          end else if (rdPend_r) begin
            state_r <= IDLE;
            done_r  <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sifh_hist_rmw_ctrl.sv
// Directed bench for sifh_hist_rmw_ctrl with a behavioural 1R/1W SRAM model
// (read returns the pre-write value when read and write collide).
module tb_sifh_hist_rmw_ctrl;
  localparam int DATA_W = 10;
  localparam int BIN_W  = 4;
  localparam int PIX_W  = 2;
  localparam int CNT_W  = 4;
  localparam int ADDR_W = PIX_W + BIN_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              res, start, frame_done, din_valid;
  logic              din_ready;
  logic [DATA_W-1:0] din_data;
  logic [PIX_W-1:0]  din_pix;
  logic [ADDR_W-1:0] ram_raddr, ram_waddr, rd_addr;
  logic              ram_ren, ram_wen, rd_valid, busy, done;
  logic [CNT_W-1:0]  ram_rdata, ram_wdata, rd_count;

  logic [CNT_W-1:0]  mem [DEPTH];
  int                expc [DEPTH];
  int                checks = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  sifh_hist_rmw_ctrl #(.DATA_W(DATA_W), .BIN_W(BIN_W), .PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .res(res), .start(start), .frame_done(frame_done),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_pix(din_pix),
    .ram_raddr(ram_raddr), .ram_ren(ram_ren), .ram_rdata(ram_rdata),
    .ram_waddr(ram_waddr), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_count(rd_count),
    .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [PIX_W-1:0] pix, input logic [DATA_W-1:0] data);
    din_valid = 1'b1;
    din_pix   = pix;
    din_data  = data;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic clearExp();
    for (int i = 0; i < DEPTH; i++) expc[i] = 0;
  endtask

  task automatic startFrame();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkVal("clear_busy", busy, 1);
    checkVal("clear_wen", ram_wen, 1);
    checkVal("clear_waddr0", ram_waddr, 0);
    checkVal("clear_wdata", ram_wdata, 0);
    repeat (63) tick();
    checkVal("clear_last_ready", din_ready, 0);
    checkVal("clear_last_waddr", ram_waddr, 63);
    tick();
    checkVal("accum_ready", din_ready, 1);
  endtask

  task automatic endAndReadout(input string name);
    int n;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    din_valid  = 1'b0;
    checkVal({name, "_drain_ready"}, din_ready, 0);
    n = 0;
    while (!rd_valid && n < 10) begin
      tick();
      n++;
    end
    checkVal({name, "_latency"}, n, 3);
    for (int i = 0; i < DEPTH; i++) begin
      checkVal($sformatf("%s_valid%0d", name, i), rd_valid, 1);
      checkVal($sformatf("%s_addr%0d", name, i), rd_addr, i);
      checkVal($sformatf("%s_cnt%0d", name, i), rd_count, expc[i]);
      checkVal($sformatf("%s_cor%0d", name, i), {ram_wen, ram_waddr, ram_wdata}, {1'b1, 6'(i), 4'd0});
      tick();
    end
    checkVal({name, "_done"}, done, 1);
    checkVal({name, "_done_noval"}, rd_valid, 0);
    tick();
    checkVal({name, "_done_pulse"}, done, 0);
    checkVal({name, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    res = 1'b0; start = 1'b0; frame_done = 1'b0; din_valid = 1'b0;
    din_data = 10'd0; din_pix = 2'd0;
    tick();
    tick();
    checkVal("rst_busy", busy, 0);
    checkVal("rst_ready", din_ready, 0);
    checkVal("rst_ram", {ram_ren, ram_wen, ram_raddr, ram_waddr, ram_wdata}, 0);
    checkVal("rst_rd", {rd_valid, rd_addr, rd_count, done}, 0);
    res = 1'b1;
    tick();

    din_valid = 1'b1; din_pix = 2'd1; din_data = 10'h3C0;
    #1;
    checkVal("idle_ignore_ren", ram_ren, 0);
    checkVal("idle_ignore_wen", ram_wen, 0);
    din_valid = 1'b0;
    tick();

    // Clear check
    clearExp();
    startFrame();
    endAndReadout("clr");

    // Hazard: five back-to-back samples to addr 31
    clearExp();
    expc[31] = 5;
    startFrame();
    repeat (5) sample(2'd1, 10'h3C0);
    endAndReadout("haz");

    // Alternation 5/6 then gap then 5
    clearExp();
    expc[5] = 4;
    expc[6] = 3;
    startFrame();
    for (int k = 0; k < 6; k++) sample(2'd0, (k % 2 == 0) ? 10'h140 : 10'h180);
    tick();
    sample(2'd0, 10'h140);
    endAndReadout("alt");

    // Saturation: 20 samples to addr 0, last one together with frame_done
    clearExp();
    expc[0] = 15;
    startFrame();
    repeat (19) sample(2'd0, 10'h000);
    din_valid = 1'b1; din_pix = 2'd0; din_data = 10'h000;
    endAndReadout("sat");

    // Clear-on-read: second frame with one sample to addr 2
    clearExp();
    expc[2] = 1;
    startFrame();
    sample(2'd0, 10'h080);
    endAndReadout("cor");

    // Reset mid-ACCUM
    startFrame();
    sample(2'd3, 10'h2C0);
    sample(2'd3, 10'h2C0);
    din_valid = 1'b1;
    res = 1'b0;
    tick();
    din_valid = 1'b0;
    checkVal("mid_rst_busy", busy, 0);
    checkVal("mid_rst_ready", din_ready, 0);
    checkVal("mid_rst_wen", ram_wen, 0);
    res = 1'b1;
    tick();
    clearExp();
    startFrame();
    endAndReadout("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sifh_hist_rmw_ctrl.md
Name: sifh_hist_rmw_ctrl

Overview:
- Sequencer for the SiFH histogram SRAM: one port reads, the other writes.
- Runs the per-frame histogram as four phases: clear all bins, accumulate timestamps by read-modify-write at one sample per cycle, drain the pipeline, then read out every bin with clear-on-read.
- Sits between the timestamp front end and the dual-port SRAM macro.
- Owns all SRAM addressing, enables and read-after-write hazard forwarding.

Parameters:
- DATA_W, 10, timestamp width (Np).
- BIN_W, 4, bin-index width; bin = top BIN_W bits of the timestamp.
- PIX_W, 2, pixel-index width.
- CNT_W, 8, bin counter width (peakMax).
- ADDR_W, PIX_W+BIN_W, SRAM address width; depth = 2^ADDR_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- res  in  1  synchronous active-low reset.
- start  in  1  pulse; starts a frame from IDLE, ignored elsewhere.
- frame_done  in  1  pulse in ACCUM; ends accumulation.
- din_valid  in  1  timestamp valid.
- din_ready  out  1  high only in ACCUM.
- din_data  in  DATA_W  timestamp.
- din_pix  in  PIX_W  pixel index.
- ram_raddr  out  ADDR_W  read address.
- ram_ren  out  1  read enable, active high.
- ram_rdata  in  CNT_W  read data, valid exactly one cycle after ram_ren.
- ram_waddr  out  ADDR_W  write address.
- ram_wen  out  1  write enable, active high.
- ram_wdata  out  CNT_W  write data.
- rd_valid  out  1  readout word valid.
- rd_addr  out  ADDR_W  bin address of readout word.
- rd_count  out  CNT_W  bin count.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when READOUT completes.

Behaviour:
- Interface: single clock clk; reset res is synchronous and active-low.
- Reset (res=0 at a rising edge):
  - State becomes IDLE.
  - All outputs are 0, including ram_* addresses and data.
  - Pipeline valid flags and the forward register are cleared.
  - Reset mid-frame aborts the frame; SRAM contents are then undefined until the next CLEAR.
- States: IDLE, CLEAR, ACCUM, DRAIN, READOUT.
- IDLE: start=1 -> CLEAR with the sweep counter at 0.
- CLEAR:
  - Each cycle: ram_wen=1, ram_waddr=counter, ram_wdata=0; counter increments.
  - After writing address 2^ADDR_W-1 -> ACCUM.
  - Takes exactly 2^ADDR_W cycles.
- ACCUM pipeline (din_ready=1, full throughput):
  - S0: when din_valid, ram_ren=1 and ram_raddr={din_pix, din_data[DATA_W-1 -: BIN_W]}. The address and a valid flag are registered into S1.
  - S1 (next cycle), base count:
    - If the forward register is valid and its address equals the S1 address, use the forward register's data.
    - Otherwise use ram_rdata.
  - S1 write: ram_wen=1, ram_waddr=S1 address, ram_wdata=sat(base+1).
  - The same write (address, data) is captured into the forward register for one cycle.
  - Saturation: a count of 2^CNT_W-1 stays 2^CNT_W-1; it never wraps.
  - SRAM writes are visible to reads issued on the following cycle. A read issued in the same cycle as a write to the same address returns stale data; the forward register covers that case.
  - Back-to-back same-bin samples therefore count exactly, with no bubbles.
  - frame_done=1: any sample presented in the same cycle is still accepted; the next state is DRAIN.
- DRAIN:
  - din_ready=0.
  - Stays 2 cycles so the last S1 write and the forward register retire.
  - Then -> READOUT with the sweep counter at 0.
- READOUT:
  - Cycle t: ram_ren=1 at the counter address.
  - Cycle t+1: rd_valid=1, rd_addr=that address, rd_count=ram_rdata; the same cycle writes 0 to that address (clear-on-read).
  - Streams one word per cycle with no backpressure.
  - The last word appears 2^ADDR_W+1 cycles after entry.
  - done pulses on the cycle after the last rd_valid; state -> IDLE.
- Outside ACCUM, din_valid is ignored: no RAM access and no count change.
- start outside IDLE and frame_done outside ACCUM are ignored.
- ram_ren and ram_wen are never asserted in IDLE.

Test Plan:
- Clear check: reset, start, frame_done immediately, then read out -> 64 words (PIX_W=2, BIN_W=4), rd_addr 0..63, all rd_count=0, done exactly one cycle after the last word.
- Hazard check: 5 consecutive cycles of din_pix=1, din_data=10'h3C0 (bin 15, addr 31) -> readout addr 31 gives count 5, all other addresses 0.
- Alternation check: samples alternating addr 5 / addr 6 for 6 cycles, then addr 5 with a one-cycle gap -> counts 4 and 3.
- Saturation: CNT_W=4, 20 samples to addr 0 -> rd_count=15.
- Clear-on-read: second frame with 1 sample to addr 2 -> rd_count=1 at addr 2; the previous frame's counts do not appear.
- Reset mid-ACCUM: res=0 for one cycle -> busy=0, din_ready=0, ram_wen=0 next cycle; then start reruns CLEAR and the readout is all zero.
